// File: rtl/router_in_arbiter_pkg.sv
// Shared types and the round-robin select used by the router input arbiter
// and any other router-side arbitration point.
package router_pkg;

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    localparam int ROUTER_DW = 8;
    localparam int MAX_SRC   = 8;

    // Rotate req so ptr sits at bit 0, take the lowest set bit, rotate the index back.
    function automatic logic [2:0] rr_select(input logic [MAX_SRC-1:0] req,
                                             input logic [2:0] ptr, input int n);
        logic [MAX_SRC-1:0] rot;
        int j;
        rot = '0;
        rr_select = ptr;
        for (int i = 0; i < MAX_SRC; i++) begin
            if (i < n) begin
                j = int'(ptr) + i;
                if (j >= n) j = j - n;
                rot[i] = req[j];
            end
        end
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (rot[i]) begin
                j = int'(ptr) + i;
                if (j >= n) j = j - n;
                rr_select = 3'(j);
            end
        end
    endfunction

endpackage

// File: rtl/router_in_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, with wrap.
module router_rr_picker
    import router_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [MAX_SRC-1:0] w_req8;
    logic [2:0]         w_idx;

    always_comb begin
        w_req8 = '0;
        w_req8[N-1:0] = i_req;
        w_idx = rr_select(w_req8, 3'(i_ptr), N);
        o_idx = IW'(w_idx);
        o_any = |i_req;
        o_onehot = '0;
        if (o_any) o_onehot[o_idx] = 1'b1;
    end

endmodule

// File: rtl/router_in_arbiter.sv
// Packet-level round-robin arbiter sharing the router's single input port
// between NUM_SRC sources; adds a post-packet gap, stall watchdog and done pulse.
module router_in_arbiter
    import router_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DW         = ROUTER_DW,
    parameter int GAP_CYCLES = 2,
    parameter int MAX_STALL  = 255
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [NUM_SRC-1:0]    src_pkt_valid,
    input  logic [NUM_SRC*DW-1:0] src_data,
    output logic [NUM_SRC-1:0]    src_busy,
    input  logic                  busy,
    output logic                  pkt_valid,
    output logic [DW-1:0]         data_in,
    output logic [NUM_SRC-1:0]    grant,
    output logic                  pkt_done,
    output logic                  stall_err
);

    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int SW = $clog2(MAX_STALL + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    state_t               r_state, w_nxt;
    logic [IW-1:0]        r_g, r_rr;
    logic [NUM_SRC-1:0]   r_grant;
    logic [GW-1:0]        r_gap;
    logic [SW-1:0]        r_stall;
    logic                 r_pkt_done, r_stall_err;

    logic [NUM_SRC-1:0]   w_pick_oh;
    logic [IW-1:0]        w_pick_idx;
    logic                 w_any;
    logic                 w_sel_valid;
    logic [DW-1:0]        w_sel_data;
    logic                 w_end;

    router_rr_picker #(.N(NUM_SRC), .IW(IW)) u_picker (
        .i_req    (src_pkt_valid),
        .i_ptr    (r_rr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_any    (w_any)
    );

    assign w_sel_valid = src_pkt_valid[r_g];
    assign w_sel_data  = src_data[r_g*DW +: DW];
    // Parity byte is the one seen with pkt_valid low; it only counts once the router takes it.
    assign w_end       = (r_state == XFER) && !w_sel_valid && !busy;

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any) w_nxt = XFER;
            XFER:    if (w_end) w_nxt = GAP;
            GAP:     if (r_gap == GW'(GAP_CYCLES - 1)) w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    always_comb begin
        pkt_valid = 1'b0;
        data_in   = '0;
        src_busy  = '1;
        grant     = '0;
        if (r_state == XFER) begin
            pkt_valid     = w_sel_valid;
            data_in       = w_sel_data;
            src_busy[r_g] = busy;
            grant         = r_grant;
        end
    end

    assign pkt_done  = r_pkt_done;
    assign stall_err = r_stall_err;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_g         <= '0;
            r_rr        <= '0;
            r_grant     <= '0;
            r_gap       <= '0;
            r_stall     <= '0;
            r_pkt_done  <= 1'b0;
            r_stall_err <= 1'b0;
        end else begin
            r_state    <= w_nxt;
            r_pkt_done <= w_end;
            if (r_state == IDLE && w_any) begin
                r_g     <= w_pick_idx;
                r_grant <= w_pick_oh;
            end
            // Pointer moves only on packet completion so a stalled owner keeps its turn.
            if (w_end) r_rr <= (r_g == IW'(NUM_SRC - 1)) ? '0 : r_g + 1'b1;
            if (r_state == GAP) r_gap <= r_gap + 1'b1;
            else                r_gap <= '0;
            if (r_state == XFER && busy) begin
                if (r_stall != SW'(MAX_STALL)) r_stall <= r_stall + 1'b1;
                if (r_stall >= SW'(MAX_STALL - 1)) r_stall_err <= 1'b1;
            end else begin
                r_stall <= '0;
            end
        end
    end

endmodule

// File: tb/tb_router_in_arbiter.sv
// Scoreboard bench for router_in_arbiter: per-source packet drivers, byte monitor, scenario tasks.
module tb_router_in_arbiter;

    localparam int NS = 4;
    localparam int DW = 8;

    logic            clock = 1'b0;
    logic            resetn = 1'b0;
    logic            busy = 1'b0;
    logic [NS-1:0]   src_pkt_valid;
    logic [NS*DW-1:0] src_data;
    logic [NS-1:0]   src_busy;
    logic            pkt_valid;
    logic [DW-1:0]   data_in;
    logic [NS-1:0]   grant;
    logic            pkt_done;
    logic            stall_err;

    router_in_arbiter #(.NUM_SRC(NS), .DW(DW), .GAP_CYCLES(2), .MAX_STALL(4)) dut (
        .clock(clock), .resetn(resetn), .src_pkt_valid(src_pkt_valid), .src_data(src_data),
        .src_busy(src_busy), .busy(busy), .pkt_valid(pkt_valid), .data_in(data_in),
        .grant(grant), .pkt_done(pkt_done), .stall_err(stall_err)
    );

    always #5 clock = ~clock;

    typedef struct {int src; logic [7:0] d; logic v;} exp_t;
    typedef struct {int src; logic [7:0] d; logic v; int cyc;} obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];
    int   done_cyc[$];
    int   obs_rd = 0;
    int   n_vec = 0, n_err = 0;
    int   cyc = 0;

    logic [7:0] pmem [NS][64];
    int         plen [NS];
    int         ld_cnt [NS];
    int         ld_seen [NS];
    int         ld_cyc [NS];
    logic [7:0] mem [NS][64];
    int         len [NS];
    int         pos [NS];
    logic       active [NS];
    logic       acc [NS];

    always @(posedge clock) cyc <= cyc + 1;

    // Source drivers and output monitor: everything happens on the falling edge.
    always @(negedge clock) begin
        obs_t o;
        if (!resetn) begin
            for (int i = 0; i < NS; i++) begin
                active[i] = 1'b0; acc[i] = 1'b0; pos[i] = 0; ld_seen[i] = ld_cnt[i];
            end
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (acc[i]) begin
                    pos[i]++;
                    if (pos[i] == len[i]) active[i] = 1'b0;
                end
                if (!active[i] && ld_seen[i] != ld_cnt[i]) begin
                    for (int k = 0; k < 64; k++) mem[i][k] = pmem[i][k];
                    len[i] = plen[i]; pos[i] = 0; active[i] = 1'b1;
                    ld_seen[i] = ld_cnt[i]; ld_cyc[i] = cyc;
                end
            end
        end
        for (int i = 0; i < NS; i++) begin
            src_pkt_valid[i] = active[i] && (pos[i] != len[i] - 1);
            src_data[i*DW +: DW] = active[i] ? mem[i][pos[i]] : 8'h00;
        end
        #1;
        for (int i = 0; i < NS; i++) begin
            acc[i] = resetn && active[i] && grant[i] && !busy;
            if (acc[i]) begin
                o.src = i; o.d = data_in; o.v = pkt_valid; o.cyc = cyc;
                obs_q.push_back(o);
            end
        end
        if (resetn && pkt_done) done_cyc.push_back(cyc);
    end

    task automatic send(input int s, input logic [7:0] hdr, input logic [7:0] seed);
        int n, t;
        logic [7:0] par, b;
        exp_t e;
        t = 0;
        while (ld_seen[s] != ld_cnt[s] && t < 300) begin @(negedge clock); #2; t++; end
        if (t >= 300) begin n_vec++; n_err++; $display("FAIL load_timeout src%0d", s); end
        n = int'(hdr[7:2]);
        par = hdr;
        pmem[s][0] = hdr;
        e.src = s; e.d = hdr; e.v = 1'b1; exp_q.push_back(e);
        for (int k = 0; k < n; k++) begin
            b = seed + 8'(k);
            par ^= b;
            pmem[s][k+1] = b;
            e.d = b; exp_q.push_back(e);
        end
        pmem[s][n+1] = par;
        e.d = par; e.v = 1'b0; exp_q.push_back(e);
        plen[s] = n + 2;
        ld_cnt[s]++;
    endtask

    task automatic wait_obs(input int n);
        int t = 0;
        while (obs_q.size() < obs_rd + n && t < 500) begin @(negedge clock); #2; t++; end
        if (t >= 500) begin n_vec++; n_err++; $display("FAIL obs_timeout got %0d want %0d", obs_q.size() - obs_rd, n); end
    endtask

    task automatic wait_grant(input logic [NS-1:0] g);
        int t = 0;
        @(negedge clock); #2;
        while (grant !== g && t < 300) begin @(negedge clock); #2; t++; end
        if (t >= 300) begin n_vec++; n_err++; $display("FAIL grant_timeout got %b want %b", grant, g); end
    endtask

    task automatic test_reset_init();
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        #2;
        n_vec++;
        if ({grant, src_busy, pkt_valid, data_in, pkt_done, stall_err} !== {4'h0, 4'hF, 1'b0, 8'h00, 2'b00}) begin
            n_err++;
            $display("FAIL reset_init got g=%b sb=%b v=%b d=%h pd=%b se=%b want g=0000 sb=1111 rest 0",
                     grant, src_busy, pkt_valid, data_in, pkt_done, stall_err);
        end
        resetn = 1'b1;
    endtask

    task automatic test_single();
        exp_t e; obs_t o;
        int prev_src, prev_cyc, par_cyc;
        send(1, 8'h05, 8'hAA);
        @(negedge clock); #2;
        n_vec++;
        if (grant !== 4'b0000) begin n_err++; $display("FAIL single_decide got %b want 0000", grant); end
        @(negedge clock); #2;
        n_vec++;
        if (grant !== 4'b0010) begin n_err++; $display("FAIL single_grant got %b want 0010", grant); end
        wait_obs(3);
        n_vec++;
        if (obs_q.size() > obs_rd && obs_q[obs_rd].cyc !== ld_cyc[1] + 1) begin
            n_err++; $display("FAIL single_latency got %0d want %0d", obs_q[obs_rd].cyc, ld_cyc[1] + 1);
        end
        par_cyc = -100;
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++; n_vec++; par_cyc = o.cyc;
            if (o.src !== e.src || o.d !== e.d || o.v !== e.v) begin
                n_err++; $display("FAIL single_byte got s%0d %h v%b want s%0d %h v%b", o.src, o.d, o.v, e.src, e.d, e.v);
            end
        end
        @(negedge clock); #2;
        n_vec++;
        if (done_cyc.size() == 0 || done_cyc[$] !== par_cyc + 1) begin
            n_err++; $display("FAIL single_done got %0d want %0d", (done_cyc.size() > 0) ? done_cyc[$] : -1, par_cyc + 1);
        end
        // rr_ptr is now 2: src2 must beat src0
        send(2, 8'h02, 8'h00);
        send(0, 8'h04, 8'h31);
        wait_obs(exp_q.size());
        prev_src = -1; prev_cyc = 0;
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++; n_vec++;
            if (o.src !== e.src || o.d !== e.d || o.v !== e.v) begin
                n_err++; $display("FAIL rr_order got s%0d %h v%b want s%0d %h v%b", o.src, o.d, o.v, e.src, e.d, e.v);
            end
            if (prev_src >= 0 && o.src != prev_src) begin
                n_vec++;
                if (o.cyc !== prev_cyc + 4) begin n_err++; $display("FAIL rr_gap got %0d want %0d", o.cyc - prev_cyc, 4); end
            end
            prev_src = o.src; prev_cyc = o.cyc;
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        exp_t e; obs_t o;
        send(3, 8'h0F, 8'h70);
        wait_grant(4'b1000);
        @(negedge clock); #3;
        resetn = 1'b0;
        #1;
        n_vec++;
        if ({grant, pkt_valid, data_in, src_busy} !== {4'h0, 1'b0, 8'h00, 4'hF}) begin
            n_err++; $display("FAIL reset_mid got g=%b v=%b d=%h sb=%b want g=0000 v=0 d=00 sb=1111", grant, pkt_valid, data_in, src_busy);
        end
        @(negedge clock); #2;
        resetn = 1'b1;
        obs_rd = obs_q.size();
        exp_q.delete();
        // rr_ptr was 1 before reset; after reset src0 must win over src1
        send(0, 8'h04, 8'h22);
        send(1, 8'h05, 8'h11);
        wait_obs(exp_q.size());
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++; n_vec++;
            if (o.src !== e.src || o.d !== e.d || o.v !== e.v) begin
                n_err++; $display("FAIL reset_rr got s%0d %h v%b want s%0d %h v%b", o.src, o.d, o.v, e.src, e.d, e.v);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_contention();
        exp_t e; obs_t o;
        int prev_src, prev_cyc;
        @(negedge clock); #2; resetn = 1'b0;
        @(negedge clock); #2; resetn = 1'b1;
        send(0, 8'h04, 8'h81);
        send(2, 8'h0A, 8'h91);
        send(3, 8'h07, 8'hA1);
        wait_obs(exp_q.size());
        prev_src = -1; prev_cyc = 0;
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++; n_vec++;
            if (o.src !== e.src || o.d !== e.d || o.v !== e.v) begin
                n_err++; $display("FAIL contention got s%0d %h v%b want s%0d %h v%b", o.src, o.d, o.v, e.src, e.d, e.v);
            end
            if (prev_src >= 0 && o.src != prev_src) begin
                n_vec++;
                if (o.cyc !== prev_cyc + 4) begin n_err++; $display("FAIL contention_gap got %0d want %0d", o.cyc - prev_cyc, 4); end
            end
            prev_src = o.src; prev_cyc = o.cyc;
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        exp_t e; obs_t o;
        logic [7:0] par;
        par = 8'h0D ^ 8'hB0 ^ 8'hB1 ^ 8'hB2;
        send(1, 8'h0D, 8'hB0);
        wait_grant(4'b0010);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clock);
            busy = ((k >= 2 && k <= 4) || k == 7 || k == 8);
            #2;
            if (k >= 2 && k <= 4) begin
                n_vec++;
                if (data_in !== 8'hB1 || src_busy !== 4'b1111 || pkt_valid !== 1'b1) begin
                    n_err++; $display("FAIL bp_hold k=%0d got d=%h sb=%b v=%b want d=b1 sb=1111 v=1", k, data_in, src_busy, pkt_valid);
                end
            end
            if (k == 7 || k == 8) begin
                n_vec++;
                if (pkt_valid !== 1'b0 || data_in !== par || pkt_done !== 1'b0) begin
                    n_err++; $display("FAIL bp_parity k=%0d got v=%b d=%h pd=%b want v=0 d=%h pd=0", k, pkt_valid, data_in, pkt_done, par);
                end
            end
            if (k == 10) begin
                n_vec++;
                if (pkt_done !== 1'b1) begin n_err++; $display("FAIL bp_done got %b want 1", pkt_done); end
            end
        end
        busy = 1'b0;
        wait_obs(exp_q.size());
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++; n_vec++;
            if (o.src !== e.src || o.d !== e.d || o.v !== e.v) begin
                n_err++; $display("FAIL bp_byte got s%0d %h v%b want s%0d %h v%b", o.src, o.d, o.v, e.src, e.d, e.v);
            end
        end
        exp_q.delete();
        n_vec++;
        if (stall_err !== 1'b0) begin n_err++; $display("FAIL bp_no_stall got %b want 0", stall_err); end
    endtask

    task automatic test_watchdog();
        exp_t e; obs_t o;
        send(2, 8'h06, 8'hC0);
        wait_grant(4'b0100);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            busy = (k <= 6);
            #2;
            if (k == 4) begin
                n_vec++;
                if (stall_err !== 1'b0) begin n_err++; $display("FAIL wd_early got %b want 0", stall_err); end
            end
            if (k == 5 || k == 10) begin
                n_vec++;
                if (stall_err !== 1'b1) begin n_err++; $display("FAIL wd_set k=%0d got %b want 1", k, stall_err); end
            end
        end
        busy = 1'b0;
        wait_obs(exp_q.size());
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++; n_vec++;
            if (o.src !== e.src || o.d !== e.d || o.v !== e.v) begin
                n_err++; $display("FAIL wd_byte got s%0d %h v%b want s%0d %h v%b", o.src, o.d, o.v, e.src, e.d, e.v);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_fairness();
        exp_t e; obs_t o;
        send(0, 8'h08, 8'hD0);
        wait_grant(4'b0001);
        send(3, 8'h07, 8'hE0);
        send(0, 8'h04, 8'hF0);
        wait_obs(exp_q.size());
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front(); o = obs_q[obs_rd]; obs_rd++; n_vec++;
            if (o.src !== e.src || o.d !== e.d || o.v !== e.v) begin
                n_err++; $display("FAIL fairness got s%0d %h v%b want s%0d %h v%b", o.src, o.d, o.v, e.src, e.d, e.v);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset_init();
        test_single();
        test_reset_mid();
        test_contention();
        test_backpressure();
        test_watchdog();
        test_fairness();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
